// File: rtl/add62_7_share_arbiter.sv
// Round-robin arbiter sharing one 62-bit + 7-bit adder among NUM_REQ requesters.
// Two registered stages: operand regs drive the adder, result regs capture its sum.
module add62_7_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*62-1:0] req_a,
    input  logic [NUM_REQ*7-1:0]  req_b,
    output logic [61:0]           add_a,
    output logic [6:0]            add_b,
    input  logic [62:0]           add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [62:0]           rsp_sum,
    output logic [ID_W-1:0]       rsp_id
);

    localparam int unsigned NR = NUM_REQ;

    // Operand stage
    logic [61:0]         r_op_a;
    logic [6:0]          r_op_b;
    logic [ID_W-1:0]     r_op_id;
    logic                r_op_valid;

    // Result stage
    logic [62:0]         r_rsp_sum;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_valid;

    // Round-robin start pointer
    logic [ID_W-1:0]     r_rr_ptr;

    logic                w_s2_free;
    logic                w_s1_adv;
    logic                w_s1_free;
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]  w_req_rot;
    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    int unsigned         w_pos;
    logic                w_accept;
    logic [61:0]         w_sel_a;
    logic [6:0]          w_sel_b;
    logic [ID_W-1:0]     w_next_ptr;

    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_s1_adv  = r_op_valid && w_s2_free;
    assign w_s1_free = !r_op_valid || w_s1_adv;

    // Rotate the request vector so bit 0 corresponds to r_rr_ptr; the first set
    // bit of the rotated vector is then the round-robin winner.
    assign w_req_dbl = {req_valid, req_valid};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

    // Priority search from the round-robin pointer, mapping back to a requester index
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_pos   = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_pos   = 32'(r_rr_ptr) + k;
                if (w_pos >= NR) begin
                    w_pos = w_pos - NR;
                end
                w_grant = ID_W'(w_pos);
            end
        end
    end

    // Reset gates the handshake so req_ready is low while rst_n is asserted
    assign w_accept   = rst_n && w_found && w_s1_free;
    assign w_next_ptr = (w_grant == ID_W'(NR - 1)) ? '0 : w_grant + ID_W'(1);

    // One-hot ready and operand mux for the granted requester
    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (w_grant == ID_W'(i)) begin
                req_ready[i] = w_accept;
                w_sel_a      = req_a[i*62 +: 62];
                w_sel_b      = req_b[i*7 +: 7];
            end
        end
    end

    // Operand stage load/drain and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= '0;
            r_op_valid <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_accept) begin
            r_op_a     <= w_sel_a;
            r_op_b     <= w_sel_b;
            r_op_id    <= w_grant;
            r_op_valid <= 1'b1;
            r_rr_ptr   <= w_next_ptr;
        end else if (w_s1_adv) begin
            r_op_valid <= 1'b0;
        end
    end

    // Result stage captures the adder output or drains on consumer accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_rsp_sum   <= add_sum;
            r_rsp_id    <= r_op_id;
            r_rsp_valid <= 1'b1;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign add_a     = r_op_a;
    assign add_b     = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_add62_7_share_arbiter.sv
// Bench for add62_7_share_arbiter: transaction-queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_add62_7_share_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*62-1:0] req_a;
    logic [N*7-1:0]  req_b;
    logic [61:0]     add_a;
    logic [6:0]      add_b;
    logic [62:0]     add_sum;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [62:0]     rsp_sum;
    logic [1:0]      rsp_id;

    add62_7_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    // The shared adder itself
    assign add_sum = {1'b0, add_a} + {56'd0, add_b};

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction model: in-flight items oldest first; head_s2 says the head sits in the result slot
    typedef struct {
        logic [61:0] a;
        logic [6:0]  b;
        int          id;
    } item_t;

    item_t mq[$];
    bit    head_s2 = 0;
    int    mrr     = 0;

    function automatic void model_eval(output bit rv, output logic [N-1:0] rdy,
                                       output bit s1o, output int s1i, output bit s2f,
                                       output bit acc, output int g);
        bit s1f;
        bit found;
        rv  = (mq.size() > 0) && head_s2;
        s1i = head_s2 ? 1 : 0;
        s1o = mq.size() > s1i;
        s2f = !rv || rsp_ready;
        s1f = !s1o || s2f;
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(mrr + k) % N]) begin
                found = 1;
                g = (mrr + k) % N;
            end
        end
        acc = found && s1f;
        rdy = acc ? (N'(1) << g) : '0;
    endfunction

    always @(posedge clk) cyc++;

    // Model state update on each edge using the inputs as sampled there
    always @(posedge clk or negedge rst_n) begin
        bit rv, s1o, s2f, acc;
        logic [N-1:0] rdy;
        int s1i, g;
        item_t it;
        if (!rst_n) begin
            mq.delete();
            head_s2 = 0;
            mrr = 0;
        end else begin
            model_eval(rv, rdy, s1o, s1i, s2f, acc, g);
            if (rv && rsp_ready) begin
                void'(mq.pop_front());
                head_s2 = 0;
            end
            if (s1o && s2f) head_s2 = 1;
            if (acc) begin
                it.a  = req_a[g*62 +: 62];
                it.b  = req_b[g*7 +: 7];
                it.id = g;
                mq.push_back(it);
                mrr = (g + 1) % N;
            end
        end
    end

    // Observation logs for directed checks
    int          acc_log[$];
    int          acc_cyc[$];
    logic [62:0] rsp_log_sum[$];
    int          rsp_log_id[$];
    int          rsp_cyc[$];
    logic [N-1:0] acc_sampled = '0;

    // Per-cycle compare against the model and logging, away from the active edge
    always @(negedge clk) begin
        bit rv, s1o, s2f, acc;
        logic [N-1:0] rdy;
        int s1i, g;
        logic [62:0] es;
        acc_sampled = req_valid & req_ready;
        if (rst_n) begin
            model_eval(rv, rdy, s1o, s1i, s2f, acc, g);
            chk("rsp_valid", 64'(rsp_valid), 64'(rv));
            chk("req_ready", 64'(req_ready), 64'(rdy));
            if (rv) begin
                es = {1'b0, mq[0].a} + {56'd0, mq[0].b};
                chk("rsp_sum", 64'(rsp_sum), 64'(es));
                chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
            end
            if (s1o) begin
                chk("add_a", 64'(add_a), 64'(mq[s1i].a));
                chk("add_b", 64'(add_b), 64'(mq[s1i].b));
            end
            for (int i = 0; i < N; i++) begin
                if (acc_sampled[i]) begin
                    acc_log.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_log_sum.push_back(rsp_sum);
                rsp_log_id.push_back(int'(rsp_id));
                rsp_cyc.push_back(cyc);
            end
        end else begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end
    end

    bit auto_drop = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~acc_sampled;
    endtask

    task automatic clear_logs();
        acc_log.delete(); acc_cyc.delete();
        rsp_log_sum.delete(); rsp_log_id.delete(); rsp_cyc.delete();
    endtask

    task automatic set_op(input int i, input logic [61:0] a, input logic [6:0] b);
        req_a[i*62 +: 62] = a;
        req_b[i*7 +: 7]   = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic chk_rsp(input string nm, input int k, input logic [62:0] s, input int id);
        if (rsp_log_sum.size() > k) begin
            chk({nm, "_sum"}, 64'(rsp_log_sum[k]), 64'(s));
            chk({nm, "_id"}, 64'(rsp_log_id[k]), 64'(id));
        end else begin
            chk({nm, "_present"}, 64'(rsp_log_sum.size()), 64'(k + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_sums[4];
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        // Reset values
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_add_a", 64'(add_a), 64'd0);
        chk("reset_add_b", 64'(add_b), 64'd0);
        chk("reset_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        rst_n = 1'b1;
        clear_logs();

        // Single request, maximum operands, two-cycle latency
        auto_drop = 1;
        set_op(2, 62'h3FFF_FFFF_FFFF_FFFF, 7'h7F);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        @(negedge clk);
        chk("single_lat1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("single_lat2", 64'(rsp_valid), 64'd1);
        chk("single_sum", 64'(rsp_sum), 64'h4000_0000_0000_007E);
        chk("single_id", 64'(rsp_id), 64'd2);
        repeat (3) tick();

        // All four requesting continuously from reset
        auto_drop = 0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 62'((i + 1) * 100), 7'(i));
        exp_sums = '{100, 201, 302, 403};
        req_valid = 4'b1111;
        tick();
        tick();
        rst_n = 1'b1;
        clear_logs();
        repeat (8) tick();
        req_valid = '0;
        repeat (4) tick();
        chk("rr_n_acc", 64'(acc_log.size() >= 6), 64'd1);
        chk("rr_n_rsp", 64'(rsp_log_id.size() >= 6), 64'd1);
        if (acc_log.size() >= 6 && rsp_log_id.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("rr_grant", 64'(acc_log[k]), 64'(k % 4));
                chk("rr_grant_cyc", 64'(acc_cyc[k]), 64'(acc_cyc[0] + k));
                chk("rr_rsp_id", 64'(rsp_log_id[k]), 64'(k % 4));
                chk("rr_rsp_sum", 64'(rsp_log_sum[k]), 64'(exp_sums[k % 4]));
                chk("rr_rsp_lag", 64'(rsp_cyc[k]), 64'(acc_cyc[k] + 2));
            end
        end

        // Backpressure with both stages full
        auto_drop = 1;
        do_reset();
        set_op(0, 62'd10, 7'd5);
        set_op(1, 62'd20, 7'd1);
        set_op(2, 62'd7, 7'd2);
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                chk("bp_ready_blocked", 64'(req_ready), 64'd0);
                chk("bp_valid", 64'(rsp_valid), 64'd1);
                chk("bp_sum_hold", 64'(rsp_sum), 64'd15);
                chk("bp_id_hold", 64'(rsp_id), 64'd0);
            end
        end
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk_rsp("bp_r0", 0, 63'd15, 0);
        chk_rsp("bp_r1", 1, 63'd21, 1);
        chk_rsp("bp_r2", 2, 63'd9, 2);
        if (rsp_cyc.size() >= 2) chk("bp_back_to_back", 64'(rsp_cyc[1]), 64'(rsp_cyc[0] + 1));

        // Fairness after idle
        do_reset();
        set_op(3, 62'd3, 7'd3);
        req_valid = 4'b1000;
        tick();
        tick();
        set_op(0, 62'd1, 7'd0);
        set_op(3, 62'd4, 7'd0);
        req_valid = 4'b1001;
        repeat (4) tick();
        chk("fair_n", 64'(acc_log.size()), 64'd3);
        if (acc_log.size() >= 3) begin
            chk("fair_g0", 64'(acc_log[0]), 64'd3);
            chk("fair_g1", 64'(acc_log[1]), 64'd0);
            chk("fair_g2", 64'(acc_log[2]), 64'd3);
        end

        // Zero and small operands
        do_reset();
        set_op(0, 62'h1, 7'h40);
        set_op(1, 62'h0, 7'h0);
        req_valid = 4'b0011;
        repeat (5) tick();
        chk_rsp("small", 0, 63'h41, 0);
        chk_rsp("zero", 1, 63'h0, 1);

        // Reset while both stages hold data
        do_reset();
        rsp_ready = 1'b0;
        set_op(1, 62'd11, 7'd1);
        set_op(2, 62'd22, 7'd2);
        req_valid = 4'b0110;
        tick();
        tick();
        set_op(3, 62'd33, 7'd3);
        req_valid = 4'b1010;
        #2;
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        clear_logs();
        repeat (4) tick();
        if (acc_log.size() >= 1) chk("post_rst_grant", 64'(acc_log[0]), 64'd1);
        else chk("post_rst_grant_present", 64'(acc_log.size()), 64'd1);
        chk_rsp("post_rst", 0, 63'd12, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/add62_7_share_arbiter.md
Name: add62_7_share_arbiter

Overview:
- Shares one 62-bit + 7-bit unsigned adder (63-bit sum) among NUM_REQ requesters.
- Round-robin arbitration, then a two-stage registered pipeline: operand stage drives the adder, result stage captures its sum.
- Valid/ready handshakes on both the request and response sides.
- Sits between the multiply/accumulate sequencers and the single shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*62  packed 62-bit A operands; requester i uses bits [62*i+61 : 62*i].
- req_b  in  NUM_REQ*7  packed 7-bit B operands; requester i uses bits [7*i+6 : 7*i].
- add_a  out  62  operand A to the shared adder.
- add_b  out  7  operand B to the shared adder (the adder zero-extends it).
- add_sum  in  63  combinational sum returned from the shared adder.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  63  registered sum.
- rsp_id  out  ID_W  index of the requester that issued the result.

Behaviour:
- Reset (async, rst_n=0): op_valid=0, rsp_valid=0, rr_ptr=0, op_a/op_b/op_id=0, rsp_sum=0, rsp_id=0. Outputs are then req_ready=0, add_a=0, add_b=0.
- Stage 1 (operand regs op_a, op_b, op_id, op_valid):
  - add_a=op_a and add_b=op_b, continuously.
- Stage 2 (result regs rsp_sum, rsp_id, rsp_valid).
- Flow control:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_adv = op_valid & s2_free.
  - s1_free = !op_valid | s1_adv.
- Arbitration:
  - grant = first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] = s1_free; all other bits of req_ready are 0.
  - req_ready is 0 when no request is valid.
- Accept (req_valid[g] & req_ready[g]), on the next edge:
  - op_a <= req_a[g], op_b <= req_b[g], op_id <= g, op_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No accept while s1_adv: op_valid <= 0.
- No accept and no advance: op regs hold. rr_ptr changes only on accept.
- Stage-2 load on s1_adv: rsp_sum <= add_sum, rsp_id <= op_id, rsp_valid <= 1.
- Stage-2 drain (rsp_valid & rsp_ready, no s1_adv): rsp_valid <= 0.
- Stage-2 hold: if rsp_valid & !rsp_ready, rsp regs hold.
- Latency and throughput:
  - Accept at edge N gives rsp_valid=1 after edge N+1 (2-cycle latency) with no backpressure.
  - Throughput is one accept per cycle.
- Simultaneous events:
  - Drain, advance and new accept may all occur in the same cycle with no bubble.
- Backpressure:
  - If rsp_ready=0 with both stages full, req_ready=0 for all requesters.
  - No data is lost or overwritten.
- Arithmetic: sum = A + zero-extended B, exactly 63 bits. Max 2^62-1+127 fits without overflow; bit 62 is the carry.
- Requester obligations:
  - Hold req_valid/req_a/req_b stable until accepted.
  - req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- Stability: rsp_sum/rsp_id are stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: in-flight operand and result are discarded, rsp_valid drops immediately, and rr_ptr returns to 0.

Test Plan:
- Single request: requester 2, A=62'h3FFF_FFFF_FFFF_FFFF, B=7'h7F, rsp_ready=1.
  - Required: rsp_valid two cycles after accept, rsp_sum=63'h4000_0000_0000_007E, rsp_id=2.
- All four requesting continuously, rsp_ready=1, from reset.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same sequence, lagging 2 cycles; one result per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 0 and 1 active (A=10, B=5 and A=20, B=1).
  - Required: after two accepts req_ready=0; rsp_sum=15, rsp_id=0 held stable.
  - After rsp_ready=1: results 15 (id 0) then 21 (id 1) back-to-back with no loss.
- Fairness after idle: requester 3 accepted, then only requesters 0 and 3 valid.
  - Required: next grant is 0, then 3.
- Zero operands: A=0, B=0.
  - Required: rsp_sum=0.
  - Also: A=62'h1, B=7'h40 -> rsp_sum=63'h41.
- Reset asserted while both stages are valid.
  - Required: rsp_valid=0 and req_ready=0 asynchronously.
  - After release, the first grant goes to the lowest valid index from rr_ptr=0.
